// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host initiator.
//   wb_cmd_t   : one queued command {we, adr, dat, sel}, 69 bits packed
//   wb_state_t : bus sequencer states
//   *_DEFAULT  : default parameter values for the top module
package wb_host_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } wb_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [31:0] CFG_ADDRESS_DEFAULT    = 32'h300F_FFFC;
  localparam int unsigned TMO_WIDTH              = 16;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO holding wb_cmd_t entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, din  : write request and entry
//   pop, dout  : read request and head entry (show-ahead)
//   full, empty: status flags
// Pointers carry one extra wrap bit to tell full from empty. A push while
// full is taken only when a pop happens on the same edge.
module wb_cmd_fifo
  import wb_host_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_cmd_t din,
  input  logic    pop,
  output wb_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  wb_cmd_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-access initiator driving the wbs_* port of the
// user-project wrapper. Commands are queued in a FIFO, executed one bus
// cycle each with a per-access timeout, and answered on a response port.
// Ports:
//   wb_clk_i, wb_rst_n_i           : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o         : command handshake
//   cmd_we_i/adr_i/dat_i/sel_i      : command fields
//   rsp_valid_o/rsp_ready_i         : response handshake
//   rsp_dat_o, rsp_err_o            : read data (0 for writes/timeouts), timeout flag
//   cfg_hit_o                       : 1-cycle pulse on acked write to CFG_ADDRESS
//   busy_o                          : sequencer active or commands queued
//   wbm_*                           : Wishbone initiator signals
module wb_host_initiator
  import wb_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [31:0] CFG_ADDRESS    = CFG_ADDRESS_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        cfg_hit_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  wb_state_t            state;
  wb_state_t            state_nxt;
  wb_cmd_t              fifo_din;
  wb_cmd_t              head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_has_q;
  logic                 push;
  logic                 pop;
  logic                 bus_ack;
  logic                 bus_tmo;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  assign fifo_din = {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};

  // Ready depends only on state and FIFO pointers. A slot being popped this
  // cycle counts as free, so a push at full is taken alongside the pop.
  assign cmd_ready_o = !fifo_full || pop;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state != IDLE) || !fifo_empty;

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Registered not-empty view: a freshly written entry becomes eligible one
  // cycle after it lands, so the bus starts two edges after acceptance.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) fifo_has_q <= 1'b0;
    else             fifo_has_q <= !fifo_empty;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    bus_ack   = 1'b0;
    bus_tmo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_has_q && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          bus_ack   = 1'b1;
          state_nxt = RSP;
        end else if (tmo_cnt == TMO_LAST) begin
          bus_tmo   = 1'b1;
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      tmo_cnt     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      cfg_hit_o   <= 1'b0;
    end else begin
      cfg_hit_o <= 1'b0;
      if (pop) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= head.we;
        wbm_adr_o <= head.adr;
        wbm_dat_o <= head.dat;
        wbm_sel_o <= head.sel;
        tmo_cnt   <= '0;
      end
      if (state == BUS) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
        if (bus_ack || bus_tmo) begin
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= bus_tmo;
          rsp_dat_o   <= (bus_ack && !wbm_we_o) ? wbm_dat_i : '0;
        end
        if (bus_ack && wbm_we_o && (wbm_adr_o == CFG_ADDRESS)) cfg_hit_o <= 1'b1;
      end
      if ((state == RSP) && rsp_ready_i) rsp_valid_o <= 1'b0;
    end
  end

endmodule
